// File: rtl/cen_frac_gen.sv
`default_nettype none
// ============================================================================
// Module      : cen_frac_gen
// Description : Multi-channel fractional clock-enable generator. Each channel
//               runs a phase accumulator; its carry-out becomes a registered
//               one-cycle enable strobe. Rate changes are applied glitch-free
//               at a period boundary, and a lock flag reports stable rates.
// Revision    : 1.0 - initial release
// ============================================================================
module cen_frac_gen #(
    parameter int                         NUM_CH      = 4,
    parameter int                         ACC_W       = 24,
    parameter logic [NUM_CH*ACC_W-1:0]    DEFAULT_INC = '0,
    parameter int                         LOCK_CYCLES = 256,
    localparam int                        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cen,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0][ACC_W-1:0] inc_q, inc_d;
    logic [NUM_CH-1:0]            cen_q, cen_d;
    logic                         pend_q, pend_d;
    logic [CH_W-1:0]              pend_ch_q, pend_ch_d;
    logic [ACC_W-1:0]             pend_inc_q, pend_inc_d;
    logic                         cfg_ready_q, cfg_ready_d;
    logic                         cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]             lock_cnt_q, lock_cnt_d;
    logic                         locked_q, locked_d;

    logic [NUM_CH-1:0]            w_carry;
    logic [ACC_W:0]               w_sum;
    logic                         w_accept;
    logic                         w_ch_bad;
    logic                         w_apply;

    // Phase accumulators: add the increment each enabled cycle, carry-out is next strobe.
    always_comb begin
        acc_d   = acc_q;
        cen_d   = '0;
        w_carry = '0;
        w_sum   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_sum = {1'b0, acc_q[ch]} + {1'b0, inc_q[ch]};
            if (sync) begin
                // Phase alignment wins over running; a carry here is dropped.
                acc_d[ch] = '0;
            end else if (ch_en[ch]) begin
                acc_d[ch]   = w_sum[ACC_W-1:0];
                cen_d[ch]   = w_sum[ACC_W];
                w_carry[ch] = w_sum[ACC_W];
            end
        end
    end

    // Config slot: accept one write, swap the increment in at the channel's period boundary.
    always_comb begin
        inc_d       = inc_q;
        pend_d      = pend_q;
        pend_ch_d   = pend_ch_q;
        pend_inc_d  = pend_inc_q;
        cfg_ready_d = cfg_ready_q;
        cfg_err_d   = 1'b0;
        w_apply     = 1'b0;
        w_accept    = cfg_valid & cfg_ready_q;
        w_ch_bad    = (32'(cfg_ch) >= NUM_CH);

        // A stalled, idle or re-phased channel has no boundary to wait for.
        if (pend_q) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ((pend_ch_q == CH_W'(ch)) &&
                    (w_carry[ch] || (inc_q[ch] == '0) || !ch_en[ch] || sync)) begin
                    inc_d[ch] = pend_inc_q;
                    w_apply   = 1'b1;
                end
            end
        end

        if (w_apply) begin
            pend_d      = 1'b0;
            cfg_ready_d = 1'b1;
        end

        if (w_accept) begin
            if (w_ch_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_ch_d   = cfg_ch;
                pend_inc_d  = cfg_inc;
                cfg_ready_d = 1'b0;
            end
        end
    end

    // Lock counter: restarts on a valid write, counts while no rate change is outstanding.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (w_accept && !w_ch_bad) begin
            lock_cnt_d = '0;
        end else if (!pend_d && (lock_cnt_q != CNT_W'(LOCK_CYCLES))) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
        locked_d = (lock_cnt_d == CNT_W'(LOCK_CYCLES));
    end

    // State registers with synchronous reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            acc_q       <= '0;
            inc_q       <= DEFAULT_INC;
            cen_q       <= '0;
            pend_q      <= 1'b0;
            pend_ch_q   <= '0;
            pend_inc_q  <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            cen_q       <= cen_d;
            pend_q      <= pend_d;
            pend_ch_q   <= pend_ch_d;
            pend_inc_q  <= pend_inc_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign cen       = cen_q;
    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign locked    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_cen_frac_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cen_frac_gen
// Description : Self-checking bench for cen_frac_gen (3 channels, 16-bit
//               accumulators, lock after 8 cycles). A cycle-level model
//               checks all outputs every cycle; directed literal checks pin
//               strobe timing, rate, glitch-free update, sync and lock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cen_frac_gen;

    localparam int          NUM_CH  = 3;
    localparam int          ACC_W   = 16;
    localparam int          LOCK    = 8;
    localparam int          CH_W    = 2;
    localparam longint      MOD     = 65536;
    localparam logic [47:0] DEF_INC = {16'h0000, 16'd15729, 16'h8000};

    logic              refclk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic              cfg_err;
    logic [NUM_CH-1:0] cen;
    logic              locked;

    int checks = 0;
    int errors = 0;

    cen_frac_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .DEFAULT_INC (DEF_INC),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_err   (cfg_err),
        .cen       (cen),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: integer phase per channel, strobe when the phase
    // crosses 2^ACC_W, single pending write, lock counter.
    // ------------------------------------------------------------------
    longint            m_acc [NUM_CH];
    longint            m_inc [NUM_CH];
    logic [NUM_CH-1:0] m_cen;
    bit                m_pend;
    int                m_pch;
    longint            m_pinc;
    bit                m_ready;
    bit                m_err;
    int                m_lock;
    bit                m_started = 0;
    logic [NUM_CH-1:0] m_carry;
    longint            m_tot;
    bit                m_apply, m_accept, m_bad;

    always @(posedge refclk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_acc[c] = 0;
                m_inc[c] = longint'(DEF_INC[c*ACC_W +: ACC_W]);
            end
            m_cen = '0; m_pend = 0; m_pch = 0; m_pinc = 0;
            m_ready = 1; m_err = 0; m_lock = 0; m_started = 1;
        end else if (m_started) begin
            m_carry = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_tot = m_acc[c] + m_inc[c];
                if (sync) m_acc[c] = 0;
                else if (ch_en[c]) begin
                    m_acc[c]   = m_tot % MOD;
                    m_carry[c] = (m_tot >= MOD);
                end
            end
            m_apply  = m_pend && (m_carry[m_pch] || m_inc[m_pch] == 0 || !ch_en[m_pch] || sync);
            m_accept = cfg_valid && m_ready;
            m_bad    = int'(cfg_ch) >= NUM_CH;
            m_cen    = m_carry;
            m_err    = 0;
            if (m_apply) begin
                m_inc[m_pch] = m_pinc;
                m_pend  = 0;
                m_ready = 1;
            end
            if (m_accept && m_bad) m_err = 1;
            if (m_accept && !m_bad) begin
                m_pend = 1; m_pch = int'(cfg_ch); m_pinc = longint'(cfg_inc);
                m_ready = 0; m_lock = 0;
            end else if (!m_pend && m_lock < LOCK) begin
                m_lock++;
            end
        end
        #1;
        if (m_started) begin
            check("cen",       32'(cen),       32'(m_cen));
            check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
            check("cfg_err",   32'(cfg_err),   32'(m_err));
            check("locked",    32'(locked),    32'(m_lock == LOCK));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge only)
    // ------------------------------------------------------------------
    task automatic cfg_write(input int ch, input logic [ACC_W-1:0] v);
        @(negedge refclk);
        cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_inc = v;
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 200) begin
            @(negedge refclk);
            n++;
        end
        check("ready_timeout", 32'(cfg_ready), 32'd1);
    endtask

    int cnt1;

    initial begin
        rst = 1'b1; ch_en = 3'b011; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
        repeat (3) @(negedge refclk);
        rst = 1'b0;

        // Reset release: ch0 (inc 0x8000) strobes every 2nd cycle from cycle 2,
        // locked rises 8 cycles out, ch1 (inc 15729) gives 2400 +/- 1 per 10000.
        cnt1 = 0;
        for (int k = 1; k <= 10000; k++) begin
            @(posedge refclk); #2;
            if (k <= 8) begin
                check("cen0_start",  32'(cen[0]), 32'((k % 2) == 0));
                check("locked_rise", 32'(locked), 32'(k == 8));
            end
            if (cen[1] === 1'b1) cnt1++;
        end
        checks++;
        if (cnt1 < 2399 || cnt1 > 2401) begin
            errors++;
            $display("FAIL cen1_rate actual=%0d expected=2400+/-1", cnt1);
        end

        // Bring all channels to inc 0x4000; ch2 is idle (inc 0) so it applies at once.
        wait_ready(); cfg_write(0, 16'h4000);
        wait_ready(); cfg_write(1, 16'h4000);
        @(negedge refclk); ch_en = 3'b111;
        wait_ready(); cfg_write(2, 16'h4000);
        wait_ready();
        repeat (12) @(negedge refclk);
        check("locked_before_sync", 32'(locked), 32'd1);

        // Sync pulse, then equal-rate strobes coincide; mid-period write of 0x8000
        // on ch0 finishes the 4-cycle period before switching to 2-cycle spacing.
        sync = 1'b1;
        @(posedge refclk); #2;
        check("sync_clear", 32'(cen), 32'd0);
        @(negedge refclk);
        sync = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge refclk); #2;
            check("cen12_aligned", 32'(cen[2:1]), ((k % 4) == 0) ? 32'd3 : 32'd0);
            check("cen0_glitchfree", 32'(cen[0]),
                  32'((k == 4) || (k == 8) || (k == 10) || (k == 12) || (k == 14) || (k == 16)));
            check("ready_hold", 32'(cfg_ready), 32'(!(k == 6 || k == 7)));
            check("lock_reprog", 32'(locked), 32'(k < 6 || k >= 15));
            @(negedge refclk);
            if (k == 5) begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h8000; end
            if (k == 6) cfg_valid = 1'b0;
        end

        // Write to a nonexistent channel: error pulse only.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'h1234;
        @(posedge refclk); #2;
        check("err_pulse",  32'(cfg_err),   32'd1);
        check("err_ready",  32'(cfg_ready), 32'd1);
        check("err_locked", 32'(locked),    32'd1);
        @(negedge refclk);
        cfg_valid = 1'b0;
        @(posedge refclk); #2;
        check("err_clear", 32'(cfg_err), 32'd0);

        // Frozen channel takes a new (max) increment next cycle, then resumes.
        @(negedge refclk); ch_en = 3'b110;
        repeat (3) @(negedge refclk);
        wait_ready(); cfg_write(0, 16'hFFFF);
        wait_ready();
        repeat (2) @(negedge refclk);
        ch_en = 3'b111;
        repeat (20) @(negedge refclk);

        // Reset in the middle of an update drops the pending write.
        cfg_write(1, 16'h1000);
        rst = 1'b1;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        check("rst_ready",  32'(cfg_ready), 32'd1);
        check("rst_locked", 32'(locked),    32'd0);
        check("rst_cen",    32'(cen),       32'd0);
        repeat (20) @(negedge refclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
